// File: rtl/ysyx_25010008_sram.sv
// rtl/ysyx_25010008_sram.sv - byte-addressed single-port SRAM behind an AXI4-Lite-style slave
//
// Purpose:
//   On-chip byte memory serving one transaction at a time for the load/store
//   unit. Reads return the four bytes starting at the requested address,
//   right-aligned and little-endian. Writes apply a per-bit mask to the bytes
//   starting at the requested address. Accesses touching any byte at or beyond
//   MEM_BYTES are reported as errors and never wrap.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   araddr/arvalid/arready      read address channel
//   rdata/rresp/rvalid/rready   read data channel (rresp 1 = error)
//   awaddr/awvalid/awready      write address channel
//   wdata/wstrb/wvalid/wready   write data channel, wstrb is a per-bit mask
//   bresp/bvalid/bready         write response channel (bresp 1 = error)
//
// INIT_FILE names a hex byte image for preloading; the preload itself is
// carried out by the integrating flow (memory-init attribute or simulation
// backdoor), so this module keeps no load logic of its own.

module ysyx_25010008_sram #(
    parameter int    MEM_BYTES    = 65536,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rresp,
    output logic        rvalid,
    input  logic        rready,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [31:0] wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic        bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_WAIT = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_WR_RESP = 3'd4;

    logic [7:0] mem [MEM_BYTES];

    logic [2:0]    state_q,  state_d;
    logic [31:0]   addr_q,   addr_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [31:0]   rdata_q,  rdata_d;
    logic          rresp_q,  rresp_d;
    logic          rvalid_q, rvalid_d;
    logic          bresp_q,  bresp_d;
    logic          bvalid_q, bvalid_d;

    // Byte base+k is in range. Done in 33 bits so an address near 2^32 cannot
    // wrap back into the array.
    function automatic logic in_range(input logic [31:0] base, input int k);
        in_range = ({1'b0, base} + 33'(k)) < 33'(MEM_BYTES);
    endfunction

    function automatic logic [AW-1:0] byte_idx(input logic [31:0] base, input int k);
        byte_idx = AW'(base + 32'(k));
    endfunction

    // Read path: the span is contiguous, so checking the last byte covers all four.
    logic [31:0] rd_word;
    logic        rd_err;

    always_comb begin
        rd_err  = !in_range(addr_q, 3);
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem[byte_idx(addr_q, k)];
        end
    end

    // Write path: only bytes with a nonzero mask take part in the range check,
    // so a byte store at the last address is legal even though a+3 is not.
    logic [3:0] wr_byte_en;
    logic       wr_err;
    logic       wr_fire;

    always_comb begin
        wr_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wr_byte_en[k] = |wstrb[8*k +: 8];
            if (wr_byte_en[k] && !in_range(addr_q, k)) begin
                wr_err = 1'b1;
            end
        end
    end

    assign wr_fire = wready && wvalid;

    // Storage has no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_fire && !wr_err) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_byte_en[k]) begin
                    mem[byte_idx(addr_q, k)] <=
                        (mem[byte_idx(addr_q, k)] & ~wstrb[8*k +: 8]) |
                        (wdata[8*k +: 8] & wstrb[8*k +: 8]);
                end
            end
        end
    end

    // Readies decode the state only; awready additionally yields to a
    // simultaneous read request.
    assign arready = rst && (state_q == S_IDLE);
    assign awready = rst && (state_q == S_IDLE) && !arvalid;
    assign wready  = rst && (state_q == S_WR_DATA);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;
        bresp_d  = bresp_q;
        bvalid_d = bvalid_q;
        case (state_q)
            S_IDLE: begin
                if (arvalid) begin
                    addr_d  = araddr;
                    cnt_d   = '0;
                    state_d = S_RD_WAIT;
                end else if (awvalid) begin
                    addr_d  = awaddr;
                    state_d = S_WR_DATA;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == CW'(READ_LATENCY - 1)) begin
                    rdata_d  = rd_err ? 32'h0 : rd_word;
                    rresp_d  = rd_err;
                    rvalid_d = 1'b1;
                    state_d  = S_RD_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_RESP: begin
                if (rready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (wvalid) begin
                    bresp_d  = wr_err;
                    bvalid_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= 1'b0;
            rvalid_q <= 1'b0;
            bresp_q  <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rvalid = rvalid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

endmodule

// File: tb/tb_ysyx_25010008_sram.sv
// tb/tb_ysyx_25010008_sram.sv - directed self-checking bench for ysyx_25010008_sram

module tb_ysyx_25010008_sram;

    localparam int MEM_BYTES    = 65536;
    localparam int READ_LATENCY = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic        rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [31:0] wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic        bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_25010008_sram #(
        .MEM_BYTES   (MEM_BYTES),
        .READ_LATENCY(READ_LATENCY),
        .INIT_FILE   ("")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_rvalid(output int lat);
        lat = 0;
        while (!rvalid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rvalid_timeout", {31'b0, rvalid}, 32'd1);
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bvalid_timeout", {31'b0, bvalid}, 32'd1);
    endtask

    task automatic aw_hs(input logic [31:0] a);
        int n;
        @(negedge clk);
        awaddr  = a;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("awready_timeout", {31'b0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_hs(input logic [31:0] d, input logic [31:0] m);
        int n;
        wdata  = d;
        wstrb  = m;
        wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wready_timeout", {31'b0, wready}, 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] m, output logic b);
        aw_hs(a);
        w_hs(d, m);
        wait_bvalid();
        b = bresp;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic r, output int lat);
        int n;
        @(negedge clk);
        araddr  = a;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arready_timeout", {31'b0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid(lat);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic        r;
        logic        b;
        int          lat;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", {31'b0, arready}, 32'd0);
        check("rst_awready", {31'b0, awready}, 32'd0);
        check("rst_wready",  {31'b0, wready},  32'd0);
        check("rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("rst_bvalid",  {31'b0, bvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_arready", {31'b0, arready}, 32'd1);
        check("idle_awready", {31'b0, awready}, 32'd1);

        // Word write/read with latency
        do_write(32'h100, 32'hDEADBEEF, 32'hFFFF_FFFF, b);
        check("word_bresp", {31'b0, b}, 32'd0);
        do_read(32'h100, d, r, lat);
        check("word_rdata", d, 32'hDEADBEEF);
        check("word_rresp", {31'b0, r}, 32'd0);
        check("word_latency", 32'(lat), 32'(READ_LATENCY));

        // Byte and half masks over the word
        do_write(32'h101, 32'h0000_0055, 32'h0000_00FF, b);
        check("byte_bresp", {31'b0, b}, 32'd0);
        do_write(32'h102, 32'h0000_1234, 32'h0000_FFFF, b);
        check("half_bresp", {31'b0, b}, 32'd0);
        do_read(32'h100, d, r, lat);
        check("mask_rdata", d, 32'h123455EF);
        do_read(32'h101, d, r, lat);
        check("unal_byte", {24'b0, d[7:0]}, 32'h55);
        do_read(32'h102, d, r, lat);
        check("unal_half", {16'b0, d[15:0]}, 32'h1234);

        // Unaligned word write, then read across it at a different offset
        do_write(32'h203, 32'hA1B2C3D4, 32'hFFFF_FFFF, b);
        do_read(32'h203, d, r, lat);
        check("unal_word", d, 32'hA1B2C3D4);
        do_read(32'h204, d, r, lat);
        check("unal_shift", {8'b0, d[23:0]}, 32'h00A1B2C3);

        // Partial-bit mask inside one byte: 0xEF with mask 0x0F <- 0x00 gives 0xE0
        do_write(32'h100, 32'h0000_0000, 32'h0000_000F, b);
        do_read(32'h100, d, r, lat);
        check("bit_mask", d, 32'h123455E0);
        do_write(32'h100, 32'h0000_00EF, 32'h0000_00FF, b);

        // Read backpressure; a second AR is held up meanwhile
        @(negedge clk);
        araddr  = 32'h100;
        arvalid = 1'b1;
        @(posedge clk); #1;
        araddr = 32'h203;
        wait_rvalid(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_rvalid",  {31'b0, rvalid},  32'd1);
            check("bp_rdata",   rdata,            32'h123455EF);
            check("bp_arready", {31'b0, arready}, 32'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("bp_rvalid_drop", {31'b0, rvalid}, 32'd0);
        check("bp_idle_arready", {31'b0, arready}, 32'd1);

        // Write-response backpressure
        aw_hs(32'h400);
        w_hs(32'hCAFEF00D, 32'hFFFF_FFFF);
        wait_bvalid();
        awaddr  = 32'h500;
        awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_bvalid",  {31'b0, bvalid},  32'd1);
            check("bp_awready", {31'b0, awready}, 32'd0);
        end
        awvalid = 1'b0;
        bready  = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bp_bvalid_drop", {31'b0, bvalid}, 32'd0);
        do_read(32'h400, d, r, lat);
        check("bp_wdata", d, 32'hCAFEF00D);

        // Simultaneous AR and AW: read wins
        @(negedge clk);
        araddr  = 32'h100;
        arvalid = 1'b1;
        awaddr  = 32'h300;
        awvalid = 1'b1;
        #1;
        check("sim_arready", {31'b0, arready}, 32'd1);
        check("sim_awready", {31'b0, awready}, 32'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("sim_awready_busy", {31'b0, awready}, 32'd0);
        wait_rvalid(lat);
        check("sim_rdata", rdata, 32'h123455EF);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("sim_awready_after", {31'b0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        w_hs(32'h0BADF00D, 32'hFFFF_FFFF);
        wait_bvalid();
        check("sim_bresp", {31'b0, bresp}, 32'd0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        do_read(32'h300, d, r, lat);
        check("sim_wdata", d, 32'h0BADF00D);

        // Range boundaries
        do_write(32'(MEM_BYTES - 4), 32'h11223344, 32'hFFFF_FFFF, b);
        check("top_bresp", {31'b0, b}, 32'd0);
        do_read(32'(MEM_BYTES - 4), d, r, lat);
        check("top_rdata", d, 32'h11223344);
        check("top_rresp", {31'b0, r}, 32'd0);
        do_read(32'(MEM_BYTES - 2), d, r, lat);
        check("oor_rresp", {31'b0, r}, 32'd1);
        check("oor_rdata", d, 32'h0);
        do_write(32'(MEM_BYTES), 32'hFFFFFFFF, 32'hFFFF_FFFF, b);
        check("oor_bresp", {31'b0, b}, 32'd1);
        do_write(32'(MEM_BYTES - 2), 32'h99887766, 32'hFFFF_FFFF, b);
        check("oor_part_bresp", {31'b0, b}, 32'd1);
        do_read(32'(MEM_BYTES - 4), d, r, lat);
        check("oor_unchanged", d, 32'h11223344);
        do_write(32'(MEM_BYTES - 2), 32'h0000AABB, 32'h0000_FFFF, b);
        check("edge_half_bresp", {31'b0, b}, 32'd0);
        do_read(32'(MEM_BYTES - 4), d, r, lat);
        check("edge_half_rdata", d, 32'hAABB3344);

        // Reset while a read response is pending
        @(negedge clk);
        araddr  = 32'h100;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        wait_rvalid(lat);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_rvalid",  {31'b0, rvalid},  32'd0);
        check("mid_rst_rdata",   rdata,            32'd0);
        check("mid_rst_arready", {31'b0, arready}, 32'd0);
        check("mid_rst_awready", {31'b0, awready}, 32'd0);
        check("mid_rst_wready",  {31'b0, wready},  32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_arready", {31'b0, arready}, 32'd1);
        do_read(32'h100, d, r, lat);
        check("post_rst_rdata", d, 32'h123455EF);
        check("post_rst_rresp", {31'b0, r}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
